// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer and the ALU core.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    ISSUE  = 3'd3,
    WAIT   = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Bit positions inside the 4-bit {V,N,Z,C} flag vector.
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  localparam int DEFAULT_NUM_OPS = 10;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_INC = 4'd8;
  localparam logic [3:0] OP_DEC = 4'd9;

endpackage

// File: rtl/alu_operand_sequencer_strobe_sync_edge.sv
// Two-flop synchronizer for an asynchronous level strobe plus a rising-edge
// detector; all flops reset to RESET_VAL so a strobe held across reset is silent.
module strobe_sync_edge #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= RESET_VAL;
      r_sync2 <= RESET_VAL;
      r_prev  <= RESET_VAL;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_rise = r_sync2 & ~r_prev;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Collects A, B and opcode bytes from a strobed pin bus, issues them to the ALU
// with a one-cycle start pulse, then holds the captured result and flags.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int OP_WIDTH    = 4,
  parameter int NUM_OPS     = DEFAULT_NUM_OPS,
  parameter int ALU_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    in_data,
  input  logic                in_strobe,
  input  logic                abort,
  output logic [WIDTH-1:0]    alu_a,
  output logic [WIDTH-1:0]    alu_b,
  output logic [OP_WIDTH-1:0] alu_op,
  output logic                alu_start,
  input  logic [WIDTH-1:0]    alu_result,
  input  logic [3:0]          alu_flags,
  output logic [WIDTH-1:0]    result,
  output logic [3:0]          flags,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                ovr,
  output state_t              dbg_state
);

  localparam int CW = $clog2(ALU_LATENCY + 1);
  // The ALU result is sampled one edge after the nominal latency has elapsed.
  localparam logic [CW-1:0] WAIT_LAST = CW'(ALU_LATENCY);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CW-1:0]       r_wait_cnt;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [OP_WIDTH-1:0] r_op;
  logic [WIDTH-1:0]    r_result;
  logic [3:0]          r_flags;
  logic                r_err;
  logic                r_ovr;

  logic w_byte_ev;
  logic w_op_valid;
  logic w_cap_a;
  logic w_cap_b;
  logic w_cap_op;
  logic w_bad_op;
  logic w_load_res;
  logic w_drop;

  // Protocol: one byte per synchronized strobe rising edge; alu_start is a
  // single-cycle pulse with no back-pressure, the ALU answers after ALU_LATENCY.
  strobe_sync_edge #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (in_strobe),
    .o_rise  (w_byte_ev)
  );

  assign w_op_valid = (32'(in_data[OP_WIDTH-1:0]) < 32'(NUM_OPS));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cap_a     = 1'b0;
    w_cap_b     = 1'b0;
    w_cap_op    = 1'b0;
    w_bad_op    = 1'b0;
    w_load_res  = 1'b0;
    w_drop      = 1'b0;
    if (abort) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: if (w_byte_ev) begin
          w_cap_a     = 1'b1;
          w_state_nxt = GET_B;
        end
        GET_B: if (w_byte_ev) begin
          w_cap_b     = 1'b1;
          w_state_nxt = GET_OP;
        end
        GET_OP: if (w_byte_ev) begin
          w_cap_op = 1'b1;
          if (w_op_valid) begin
            w_state_nxt = ISSUE;
          end else begin
            w_bad_op    = 1'b1;
            w_state_nxt = DONE;
          end
        end
        ISSUE: begin
          w_drop      = w_byte_ev;
          w_state_nxt = WAIT;
        end
        WAIT: begin
          w_drop = w_byte_ev;
          if (r_wait_cnt == WAIT_LAST) begin
            w_load_res  = 1'b1;
            w_state_nxt = DONE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
      r_result   <= '0;
      r_flags    <= '0;
      r_err      <= 1'b0;
      r_ovr      <= 1'b0;
    end else if (abort) begin
      // Operand registers deliberately survive an abort.
      r_wait_cnt <= '0;
      r_result   <= '0;
      r_flags    <= '0;
      r_err      <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      if (w_cap_a) begin
        r_a   <= in_data;
        r_err <= 1'b0;
        r_ovr <= 1'b0;
      end
      if (w_cap_b)  r_b  <= in_data;
      if (w_cap_op) r_op <= in_data[OP_WIDTH-1:0];
      if (w_bad_op) begin
        r_err    <= 1'b1;
        r_result <= '0;
        r_flags  <= '0;
      end
      if (w_load_res) begin
        r_result <= alu_result;
        r_flags  <= alu_flags;
      end
      if (w_drop) r_ovr <= 1'b1;
      if ((r_state == WAIT) && !w_load_res) r_wait_cnt <= r_wait_cnt + 1'b1;
      else                                  r_wait_cnt <= '0;
    end
  end

  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_op    = r_op;
  assign result    = r_result;
  assign flags     = r_flags;
  assign err       = r_err;
  assign ovr       = r_ovr;
  assign alu_start = (r_state == ISSUE);
  assign busy      = (r_state == ISSUE) || (r_state == WAIT);
  assign done      = (r_state == DONE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: two instances (ALU latency 1 and 4), a stand-in
// ALU, a transaction-level reference model checked every cycle, plus directed checks.
module tb_alu_operand_sequencer;
  import alu_seq_pkg::*;

  localparam int W    = 8;
  localparam int OW   = 4;
  localparam int NOPS = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0]  in_data    [2];
  logic          in_strobe  [2];
  logic          abort      [2];
  logic [W-1:0]  alu_a      [2];
  logic [W-1:0]  alu_b      [2];
  logic [OW-1:0] alu_op     [2];
  logic          alu_start  [2];
  logic [W-1:0]  alu_result [2];
  logic [3:0]    alu_flags  [2];
  logic [W-1:0]  result     [2];
  logic [3:0]    flags      [2];
  logic          busy       [2];
  logic          done       [2];
  logic          err        [2];
  logic          ovr        [2];
  state_t        dbg_state  [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_operand_sequencer #(
      .WIDTH(W), .OP_WIDTH(OW), .NUM_OPS(NOPS), .ALU_LATENCY((g == 0) ? 1 : 4)
    ) u_dut (
      .clk(clk), .rst(rst), .in_data(in_data[g]), .in_strobe(in_strobe[g]),
      .abort(abort[g]), .alu_a(alu_a[g]), .alu_b(alu_b[g]), .alu_op(alu_op[g]),
      .alu_start(alu_start[g]), .alu_result(alu_result[g]), .alu_flags(alu_flags[g]),
      .result(result[g]), .flags(flags[g]), .busy(busy[g]), .done(done[g]),
      .err(err[g]), .ovr(ovr[g]), .dbg_state(dbg_state[g])
    );
  end

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  // Reference ALU: returns {flags, result} with flags laid out as {V,N,Z,C}.
  function automatic logic [W+3:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [OW-1:0] op);
    logic [W:0]   t;
    logic [W-1:0] r;
    logic [3:0]   fl;
    logic         c;
    logic         v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_ADD: begin
        t = {1'b0, a} + {1'b0, b};
        c = t[W];
        v = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
      end
      OP_SUB: begin
        t = {1'b0, a} + {1'b0, ~b} + 9'd1;
        c = t[W];
        v = (a[W-1] != b[W-1]) && (t[W-1] != a[W-1]);
      end
      OP_AND:  t = {1'b0, a & b};
      OP_OR:   t = {1'b0, a | b};
      OP_XOR:  t = {1'b0, a ^ b};
      default: t = {1'b0, a};
    endcase
    r = t[W-1:0];
    fl = 4'b0000;
    fl[FLAG_C] = c;
    fl[FLAG_Z] = (r == '0);
    fl[FLAG_N] = r[W-1];
    fl[FLAG_V] = v;
    return {fl, r};
  endfunction

  // ---------------- stand-in ALU ----------------
  int           alu_cnt  [2];
  logic [W+3:0] alu_pend [2];
  initial begin
    for (int d = 0; d < 2; d++) begin
      alu_cnt[d]    = 0;
      alu_result[d] = 8'hEE;
      alu_flags[d]  = 4'hF;
    end
  end
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (alu_cnt[d] > 0) begin
        alu_cnt[d] = alu_cnt[d] - 1;
        if (alu_cnt[d] == 0) {alu_flags[d], alu_result[d]} = alu_pend[d];
      end
      if (alu_start[d]) begin
        alu_pend[d]   = alu_ref(alu_a[d], alu_b[d], alu_op[d]);
        alu_cnt[d]    = lat(d);
        alu_result[d] = 8'hEE;
        alu_flags[d]  = 4'hF;
      end
    end
  end

  // ---------------- reference model ----------------
  // Byte events: a strobe sample of 1 two edges ago preceded by a 0 the edge before.
  bit            sh        [2][3];
  int            m_nbytes  [2];
  int            m_busy    [2];
  logic [W-1:0]  m_a       [2];
  logic [W-1:0]  m_b       [2];
  logic [OW-1:0] m_op      [2];
  logic [W-1:0]  m_res     [2];
  logic [3:0]    m_flags   [2];
  logic          m_done    [2];
  logic          m_err     [2];
  logic          m_ovr     [2];
  logic          m_start   [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit ev;
      if (rst) begin
        for (int i = 0; i < 3; i++) sh[d][i] = 1'b1;
        m_nbytes[d] = 0; m_busy[d] = 0;
        m_a[d] = '0; m_b[d] = '0; m_op[d] = '0; m_res[d] = '0; m_flags[d] = '0;
        m_done[d] = 1'b0; m_err[d] = 1'b0; m_ovr[d] = 1'b0; m_start[d] = 1'b0;
      end else begin
        ev = sh[d][1] && !sh[d][2];
        sh[d][2] = sh[d][1];
        sh[d][1] = sh[d][0];
        sh[d][0] = in_strobe[d];
        m_start[d] = 1'b0;
        if (abort[d]) begin
          m_nbytes[d] = 0; m_busy[d] = 0; m_res[d] = '0; m_flags[d] = '0;
          m_done[d] = 1'b0; m_err[d] = 1'b0; m_ovr[d] = 1'b0;
        end else if (m_busy[d] > 0) begin
          if (ev) m_ovr[d] = 1'b1;
          m_busy[d] = m_busy[d] - 1;
          if (m_busy[d] == 0) begin
            m_done[d] = 1'b1;
            {m_flags[d], m_res[d]} = alu_ref(m_a[d], m_b[d], m_op[d]);
          end
        end else if (ev) begin
          if (m_nbytes[d] == 0) begin
            m_a[d] = in_data[d]; m_done[d] = 1'b0; m_err[d] = 1'b0; m_ovr[d] = 1'b0;
            m_nbytes[d] = 1;
          end else if (m_nbytes[d] == 1) begin
            m_b[d] = in_data[d];
            m_nbytes[d] = 2;
          end else begin
            m_op[d] = in_data[d][OW-1:0];
            m_nbytes[d] = 0;
            if (int'(m_op[d]) < NOPS) begin
              m_start[d] = 1'b1;
              m_busy[d]  = lat(d) + 2;
            end else begin
              m_err[d] = 1'b1; m_done[d] = 1'b1; m_res[d] = '0; m_flags[d] = '0;
            end
          end
        end
      end
    end
  end

  function automatic state_t exp_state(input int d);
    if (m_busy[d] > 0) return m_start[d] ? ISSUE : WAIT;
    if (m_done[d])     return DONE;
    if (m_nbytes[d] == 1) return GET_B;
    if (m_nbytes[d] == 2) return GET_OP;
    return IDLE;
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, d, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      check("alu_a",     d, 32'(alu_a[d]),     32'(m_a[d]));
      check("alu_b",     d, 32'(alu_b[d]),     32'(m_b[d]));
      check("alu_op",    d, 32'(alu_op[d]),    32'(m_op[d]));
      check("alu_start", d, 32'(alu_start[d]), 32'(m_start[d]));
      check("result",    d, 32'(result[d]),    32'(m_res[d]));
      check("flags",     d, 32'(flags[d]),     32'(m_flags[d]));
      check("busy",      d, 32'(busy[d]),      32'(m_busy[d] > 0));
      check("done",      d, 32'(done[d]),      32'(m_done[d]));
      check("err",       d, 32'(err[d]),       32'(m_err[d]));
      check("ovr",       d, 32'(ovr[d]),       32'(m_ovr[d]));
      check("state",     d, 32'(dbg_state[d]), 32'(exp_state(d)));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns just after the edge that captures the byte.
  task automatic send(input int d, input logic [W-1:0] v);
    in_data[d]   = v;
    in_strobe[d] = 1'b1;
    repeat (3) tick();
    in_strobe[d] = 1'b0;
  endtask

  task automatic gap(input int d);
    in_strobe[d] = 1'b0;
    repeat (2) tick();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    in_data[0] = '0; in_data[1] = '0;
    in_strobe[0] = 1'b1; in_strobe[1] = 1'b0;
    abort[0] = 1'b0; abort[1] = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();
    check("lit_rst_alu_a", 0, 32'(alu_a[0]), 32'h0);
    check("lit_rst_state", 0, 32'(dbg_state[0]), 32'(IDLE));
    check("lit_rst_done",  0, 32'(done[0]), 32'h0);
    gap(0);

    // ADD 0x5A + 0x33
    send(0, 8'h5A); gap(0); send(0, 8'h33); gap(0); send(0, 8'h00);
    check("lit_add_start_E", 0, 32'(alu_start[0]), 32'h1);
    check("lit_add_busy_E",  0, 32'(busy[0]), 32'h1);
    tick();
    check("lit_add_start_E1", 0, 32'(alu_start[0]), 32'h0);
    tick();
    check("lit_add_done_E2", 0, 32'(done[0]), 32'h0);
    tick();
    check("lit_add_done_E3", 0, 32'(done[0]), 32'h1);
    check("lit_add_result",  0, 32'(result[0]), 32'h8D);
    check("lit_add_flags",   0, 32'(flags[0]), 32'hC);
    check("lit_model_res",   0, 32'(m_res[0]), 32'h8D);
    gap(0);

    // Invalid opcode 0x0C, started from DONE
    send(0, 8'h11);
    check("lit_b2b_done_fall", 0, 32'(done[0]), 32'h0);
    check("lit_b2b_res_held",  0, 32'(result[0]), 32'h8D);
    gap(0); send(0, 8'h22); gap(0); send(0, 8'h0C);
    check("lit_bad_err",    0, 32'(err[0]), 32'h1);
    check("lit_bad_done",   0, 32'(done[0]), 32'h1);
    check("lit_bad_result", 0, 32'(result[0]), 32'h0);
    check("lit_bad_start",  0, 32'(alu_start[0]), 32'h0);
    gap(0);

    // SUB 0x70 - 0x10 back-to-back from DONE
    send(0, 8'h70);
    check("lit_sub_err_clr", 0, 32'(err[0]), 32'h0);
    gap(0); send(0, 8'h10); gap(0); send(0, 8'h01);
    repeat (3) tick();
    check("lit_sub_result", 0, 32'(result[0]), 32'h60);
    check("lit_sub_flags",  0, 32'(flags[0]), 32'h1);
    gap(0);

    // Abort in GET_OP coincident with the opcode byte event
    send(0, 8'h01); gap(0); send(0, 8'h02); gap(0);
    in_data[0] = 8'h03; in_strobe[0] = 1'b1;
    tick(); tick();
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0; in_strobe[0] = 1'b0;
    check("lit_abort_state",  0, 32'(dbg_state[0]), 32'(IDLE));
    check("lit_abort_result", 0, 32'(result[0]), 32'h0);
    check("lit_abort_a_kept", 0, 32'(alu_a[0]), 32'h01);
    check("lit_abort_b_kept", 0, 32'(alu_b[0]), 32'h02);
    gap(0);
    send(0, 8'h0F); gap(0); send(0, 8'hF1); gap(0); send(0, 8'h00);
    repeat (3) tick();
    check("lit_post_abort_done",  0, 32'(done[0]), 32'h1);
    check("lit_post_abort_res",   0, 32'(result[0]), 32'h00);
    check("lit_post_abort_flags", 0, 32'(flags[0]), 32'h3);

    // Latency 4: extra strobe during WAIT is dropped and flagged
    send(1, 8'h05); gap(1); send(1, 8'h03); gap(1); send(1, 8'h02);
    tick(); tick();
    send(1, 8'h99);
    check("lit_ovr_set",    1, 32'(ovr[1]), 32'h1);
    check("lit_ovr_busy",   1, 32'(busy[1]), 32'h1);
    check("lit_ovr_a_kept", 1, 32'(alu_a[1]), 32'h05);
    tick();
    check("lit_l4_done",   1, 32'(done[1]), 32'h1);
    check("lit_l4_result", 1, 32'(result[1]), 32'h01);
    gap(1);
    send(1, 8'h44);
    check("lit_ovr_clear", 1, 32'(ovr[1]), 32'h0);
    gap(1);

    // Reset during WAIT discards the pending result
    send(1, 8'h55); gap(1); send(1, 8'h00);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("lit_rstw_busy",  1, 32'(busy[1]), 32'h0);
    check("lit_rstw_state", 1, 32'(dbg_state[1]), 32'(IDLE));
    check("lit_rstw_a",     1, 32'(alu_a[1]), 32'h0);
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
